// File: rtl/acc_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : acc_i2c_target
// Brief    : I2C target exposing a 16-entry accelerometer register map.
// Revision : 1.0 - initial release
// ============================================================================
module acc_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h19,
    parameter logic [7:0] WHO_AM_I   = 8'h33
) (
    input  logic        clk12M,
    input  logic        rst_n,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic        sample_valid,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  ctrl_reg,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [3:0]  cnt_q, cnt_d, ptr_q, ptr_d;
    logic [6:0]  shift_q, shift_d, tx_q, tx_d;
    logic        rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic        data_ready_q, data_ready_d, pend_q, pend_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [47:0] sample_q, sample_d, pend_data_q, pend_data_d;
    logic [63:0] scratch_q, scratch_d;

    logic        scl_s, scl_prev, sda_s, sda_prev;
    logic        scl_rise, scl_fall, bus_start, bus_stop, in_read;
    logic        dr_set, dr_clr;
    logic [7:0]  rx_byte, rd_byte;
    logic [5:0]  samp_idx, scr_idx;

    // Stage [1] is the synchronized value, stage [2] its previous sample.
    assign scl_s     = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign bus_start = scl_s & scl_prev & sda_prev & ~sda_s;
    assign bus_stop  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign in_read   = (state_q == RD_DATA) || (state_q == RD_ACK);
    assign rx_byte   = {shift_q, sda_s};
    assign samp_idx  = {ptr_q[2:0] - 3'd2, 3'b000};
    assign scr_idx   = {ptr_q[2:0], 3'b000};

    always_comb begin
        rd_byte = scratch_q[scr_idx +: 8];
        case (ptr_q)
            4'h0:                             rd_byte = ctrl_q;
            4'h1:                             rd_byte = {7'b0, data_ready_q};
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: rd_byte = sample_q[samp_idx +: 8];
            4'hF:                             rd_byte = WHO_AM_I;
            default:                          rd_byte = scratch_q[scr_idx +: 8];
        endcase
    end

    always_comb begin
        scl_sync_d  = {scl_sync_q[1:0], SCL};
        sda_sync_d  = {sda_sync_q[1:0], SDA};
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        ctrl_d      = ctrl_q;
        scratch_d   = scratch_q;
        sample_d    = sample_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        dr_set      = 1'b0;
        dr_clr      = 1'b0;

        if (bus_start) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (bus_stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            // Bits are taken on SCL rise; SDA is only retimed on SCL fall.
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (shift_q == SLAVE_ADDR) begin
                                rw_d   = sda_s;
                                busy_d = 1'b1;
                            end else begin
                                state_d  = IDLE;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d  = RD_DATA;
                            tx_d     = rd_byte[6:0];
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7)
                            ptr_d = rx_byte[3:0];
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = PTR_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        state_d  = WR_DATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte[6:0];
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d = ptr_q + 4'd1;
                            case (ptr_q)
                                4'h0:                                   ctrl_d = rx_byte;
                                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: scratch_d[scr_idx +: 8] = rx_byte;
                                default: ;
                            endcase
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = WR_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d  = ptr_q + 4'd1;
                            dr_clr = (ptr_q == 4'h7);
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            tx_d     = {tx_q[5:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_d  = IDLE;
                        sda_oe_d = 1'b0;
                        busy_d   = 1'b0;
                    end else if (scl_fall) begin
                        state_d  = RD_DATA;
                        cnt_d    = 4'd0;
                        tx_d     = rd_byte[6:0];
                        sda_oe_d = ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end

        // Samples arriving mid-read are parked so the byte stream stays coherent.
        if (state_q == IDLE && pend_q) begin
            sample_d = pend_data_q;
            pend_d   = 1'b0;
            dr_set   = 1'b1;
        end
        if (sample_valid) begin
            if (in_read) begin
                pend_d      = 1'b1;
                pend_data_d = {accel_z, accel_y, accel_x};
            end else begin
                sample_d = {accel_z, accel_y, accel_x};
                pend_d   = 1'b0;
                dr_set   = 1'b1;
            end
        end
        data_ready_d = dr_set ? 1'b1 : (dr_clr ? 1'b0 : data_ready_q);
    end

    always_ff @(posedge clk12M or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            cnt_q        <= 4'd0;
            ptr_q        <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 7'd0;
            rw_q         <= 1'b0;
            sda_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            pend_q       <= 1'b0;
            ctrl_q       <= 8'h00;
            sample_q     <= 48'd0;
            pend_data_q  <= 48'd0;
            scratch_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rw_q         <= rw_d;
            sda_oe_q     <= sda_oe_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
            pend_q       <= pend_d;
            ctrl_q       <= ctrl_d;
            sample_q     <= sample_d;
            pend_data_q  <= pend_data_d;
            scratch_q    <= scratch_d;
        end
    end

    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign ctrl_reg = ctrl_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_i2c_target
// Brief    : Directed I2C transactions against acc_i2c_target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_i2c_target;

    localparam int H = 10;

    logic        clk12M       = 1'b0;
    logic        rst_n        = 1'b0;
    logic        SCL          = 1'b1;
    logic        m_drive      = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] accel_x      = 16'h0;
    logic [15:0] accel_y      = 16'h0;
    logic [15:0] accel_z      = 16'h0;
    logic [7:0]  ctrl_reg;
    logic        busy;
    wire         sda_bus;

    int n_checks    = 0;
    int n_fail      = 0;
    int dut_low_cnt = 0;

    assign sda_bus = m_drive ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #42 clk12M = ~clk12M;

    // Counts cycles where the target, not the initiator, holds SDA low.
    always @(posedge clk12M)
        if (!m_drive && sda_bus === 1'b0) dut_low_cnt <= dut_low_cnt + 1;

    acc_i2c_target #(.SLAVE_ADDR(7'h19), .WHO_AM_I(8'h33)) dut (
        .clk12M       (clk12M),
        .rst_n        (rst_n),
        .SCL          (SCL),
        .SDA          (sda_bus),
        .sample_valid (sample_valid),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .ctrl_reg     (ctrl_reg),
        .busy         (busy)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk12M);
    endtask

    task automatic i2c_start;
        m_drive = 1'b0; wait_cyc(H);
        SCL     = 1'b1; wait_cyc(H);
        m_drive = 1'b1; wait_cyc(H);
        SCL     = 1'b0; wait_cyc(H);
    endtask

    task automatic i2c_stop;
        m_drive = 1'b1; wait_cyc(H);
        SCL     = 1'b1; wait_cyc(H);
        m_drive = 1'b0; wait_cyc(H);
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_drive = ~b[i]; wait_cyc(H);
            SCL = 1'b1;      wait_cyc(H);
            SCL = 1'b0;      wait_cyc(2);
        end
        m_drive = 1'b0; wait_cyc(H);
        SCL = 1'b1;     wait_cyc(H / 2);
        ack = sda_bus;  wait_cyc(H / 2);
        SCL = 1'b0;     wait_cyc(2);
    endtask

    task automatic i2c_read(input logic nack, output logic [7:0] b);
        b = 8'h00;
        m_drive = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(H);
            SCL = 1'b1;    wait_cyc(H / 2);
            b[i] = sda_bus; wait_cyc(H / 2);
            SCL = 1'b0;    wait_cyc(2);
        end
        m_drive = ~nack; wait_cyc(H);
        SCL = 1'b1;      wait_cyc(H);
        SCL = 1'b0;      wait_cyc(2);
        m_drive = 1'b0;
    endtask

    // Write pointer, repeated START, read address; returns OR of all ACK bits.
    task automatic setup_read(input logic [7:0] p, output logic nacked);
        logic a0, a1, a2;
        i2c_start; i2c_write(8'h32, a0); i2c_write(p, a1);
        i2c_start; i2c_write(8'h33, a2);
        nacked = a0 | a1 | a2;
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        accel_x = x; accel_y = y; accel_z = z;
        sample_valid = 1'b1; wait_cyc(1);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wait_cyc(5);
        n_checks++; if (ctrl_reg !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %02h expected 00", ctrl_reg); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", sda_bus); end
        rst_n = 1'b1; wait_cyc(5);
    endtask

    task automatic test_write_ctrl;
        logic a0, a1, a2;
        i2c_start; i2c_write(8'h32, a0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_match: got %b expected 1", busy); end
        i2c_write(8'h00, a1); i2c_write(8'hA5, a2);
        n_checks++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b expected 000", {a0, a1, a2}); end
        i2c_stop;
        n_checks++; if (ctrl_reg !== 8'hA5) begin n_fail++; $display("FAIL ctrl_write: got %02h expected a5", ctrl_reg); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_sample_read;
        logic       nk;
        logic [7:0] d;
        logic [7:0] exp_b [6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
        setup_read(8'h01, nk); i2c_read(1'b1, d); i2c_stop;
        n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL status_set: got %02h expected 01", d); end
        setup_read(8'h02, nk);
        n_checks++; if (nk !== 1'b0) begin n_fail++; $display("FAIL sample_setup_ack: got %b expected 0", nk); end
        for (int i = 0; i < 6; i++) begin
            i2c_read(i == 5, d);
            n_checks++; if (d !== exp_b[i]) begin n_fail++; $display("FAIL sample_byte%0d: got %02h expected %02h", i, d, exp_b[i]); end
        end
        i2c_stop;
        setup_read(8'h01, nk); i2c_read(1'b1, d); i2c_stop;
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL status_cleared: got %02h expected 00", d); end
    endtask

    task automatic test_mismatch;
        logic a;
        int   c0;
        c0 = dut_low_cnt;
        i2c_start; i2c_write(8'h30, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL mismatch_nack: got %b expected 1", a); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
        i2c_stop;
        n_checks++; if (dut_low_cnt !== c0) begin n_fail++; $display("FAIL mismatch_sda_driven: got %0d low cycles expected 0", dut_low_cnt - c0); end
    endtask

    task automatic test_wrap;
        logic       nk;
        logic [7:0] d0, d1;
        setup_read(8'h0F, nk); i2c_read(1'b0, d0); i2c_read(1'b1, d1); i2c_stop;
        n_checks++; if (d0 !== 8'h33) begin n_fail++; $display("FAIL wrap_who_am_i: got %02h expected 33", d0); end
        n_checks++; if (d1 !== 8'hA5) begin n_fail++; $display("FAIL wrap_ctrl: got %02h expected a5", d1); end
    endtask

    task automatic test_readonly_scratch;
        logic       a0, a1, a2, a3, a4, nk;
        logic [7:0] d0, d1, d2;
        i2c_start; i2c_write(8'h32, a0); i2c_write(8'h07, a1);
        i2c_write(8'h55, a2); i2c_write(8'h5A, a3); i2c_write(8'hC3, a4); i2c_stop;
        n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin n_fail++; $display("FAIL ro_write_acks: got %b expected 00000", {a0, a1, a2, a3, a4}); end
        i2c_start; i2c_write(8'h32, a0); i2c_write(8'h07, a1); i2c_stop;
        i2c_start; i2c_write(8'h33, nk);
        i2c_read(1'b0, d0); i2c_read(1'b0, d1); i2c_read(1'b1, d2); i2c_stop;
        n_checks++; if (d0 !== 8'h9A) begin n_fail++; $display("FAIL ro_discard: got %02h expected 9a", d0); end
        n_checks++; if (d1 !== 8'h5A) begin n_fail++; $display("FAIL scratch8: got %02h expected 5a", d1); end
        n_checks++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL scratch9: got %02h expected c3", d2); end
    endtask

    task automatic test_sample_during_read;
        logic       nk;
        logic [7:0] d;
        logic [7:0] exp_a [3] = '{8'h34, 8'h12, 8'h78};
        logic [7:0] exp_c [4] = '{8'h01, 8'hFE, 8'hCA, 8'hEF};
        setup_read(8'h02, nk);
        for (int i = 0; i < 3; i++) begin
            i2c_read(i == 2, d);
            if (i == 0) pulse_sample(16'hCAFE, 16'hBEEF, 16'h0102);
            n_checks++; if (d !== exp_a[i]) begin n_fail++; $display("FAIL held_byte%0d: got %02h expected %02h", i, d, exp_a[i]); end
        end
        i2c_stop;
        setup_read(8'h01, nk);
        for (int i = 0; i < 4; i++) begin
            i2c_read(i == 3, d);
            n_checks++; if (d !== exp_c[i]) begin n_fail++; $display("FAIL pending_byte%0d: got %02h expected %02h", i, d, exp_c[i]); end
        end
        i2c_stop;
    endtask

    task automatic test_reset_mid_read;
        logic       nk;
        logic [7:0] d;
        setup_read(8'h00, nk);
        m_drive = 1'b0; wait_cyc(H);
        SCL = 1'b1;     wait_cyc(H);
        SCL = 1'b0;     wait_cyc(H / 2);
        n_checks++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL mid_read_driven: got %b expected 0", sda_bus); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_read_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda_release: got %b expected 1", sda_bus); end
        n_checks++; if (ctrl_reg !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl: got %02h expected 00", ctrl_reg); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        wait_cyc(3);
        rst_n = 1'b1; wait_cyc(H);
        i2c_start; i2c_write(8'h33, nk); i2c_read(1'b1, d); i2c_stop;
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_ptr_ctrl: got %02h expected 00", d); end
        setup_read(8'h0F, nk); i2c_read(1'b1, d); i2c_stop;
        n_checks++; if (d !== 8'h33) begin n_fail++; $display("FAIL rst_who_am_i: got %02h expected 33", d); end
        setup_read(8'h02, nk); i2c_read(1'b1, d); i2c_stop;
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_x_l: got %02h expected 00", d); end
    endtask

    initial begin
        test_reset;
        test_write_ctrl;
        test_sample_read;
        test_mismatch;
        test_wrap;
        test_readonly_scratch;
        test_sample_during_read;
        test_reset_mid_read;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
